zx8x_tape_player: RTL and testbench

- Real-time tape transmitter for the ZX80/ZX81 core. Complements the fast-load patch: it streams a .o/.p image from tape buffer RAM as a genuine cassette pulse train on the EAR line.
- The unpatched ROM LOAD routine receives it; no ROM patching is needed.
- Sits between the tape buffer RAM (1-cycle synchronous read) and the core's `tape_in` mux.
- Standard format: bit 0 = 4 pulses, bit 1 = 9 pulses, each pulse 150 µs high / 150 µs low, one gap after every bit, bytes sent MSB-first.

---
 rtl/zx8x_tape_player.sv | 229 ++++++++++++++++++++++
 tb/tb_zx8x_tape_player.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx8x_tape_player.sv
// +----------------------------------------------------------------------------+
// | Module      : zx8x_tape_player                                             |
// | Description : Real-time ZX80/ZX81 cassette transmitter. Streams a .o/.p    |
// |               image from the tape buffer RAM as a genuine EAR pulse train  |
// |               that the unpatched ROM LOAD routine can read.                |
// |               Encoding: bit 0 = 4 pulses, bit 1 = 9 pulses, each pulse     |
// |               PULSE_CYC high then PULSE_CYC low, GAP_CYC low after every   |
// |               bit, bytes MSB-first, LEADIN_CYC low before and after.       |
// | Ports       : clk_sys, reset (sync, active-high)                           |
// |               start    - 1-cycle pulse, begin playback                     |
// |               abort    - synchronous stop, no done pulse                   |
// |               zx81     - 1 = prepend blank-name byte 0x80                  |
// |               length   - image byte count, 0..2^AW                         |
// |               rd_addr  - tape buffer address (1-cycle synchronous read)    |
// |               rd_data  - buffer data, valid the cycle after rd_addr        |
// |               tape_out - EAR level, 1 = pulse high                         |
// |               busy     - playback in progress                              |
// |               done     - 1-cycle pulse on normal completion                |
// |               pause    - only with TAPE_PLAYER_PAUSE_EN: freeze playback   |
// | Option      : `define TAPE_PLAYER_PAUSE_EN adds the pause input.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module zx8x_tape_player #(
   parameter int PULSE_CYC  = 7800,
   parameter int GAP_CYC    = 67600,
   parameter int LEADIN_CYC = 26000000,
   parameter int AW         = 14
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          zx81,
   input  logic [AW:0]   length,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          tape_out,
   output logic          busy,
   output logic          done
`ifdef TAPE_PLAYER_PAUSE_EN
   ,
   input  logic          pause
`endif
);

   // Shared phase counter is sized for the longest phase.
   localparam int c_MAX_AB  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int c_MAX_CYC = (c_MAX_AB > LEADIN_CYC) ? c_MAX_AB : LEADIN_CYC;
   localparam int c_CW      = $clog2(c_MAX_CYC + 1);

   localparam logic [c_CW-1:0] c_PULSE_LD  = c_CW'(PULSE_CYC - 1);
   localparam logic [c_CW-1:0] c_GAP_LD    = c_CW'(GAP_CYC - 1);
   localparam logic [c_CW-1:0] c_LEADIN_LD = c_CW'(LEADIN_CYC - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEADIN = 3'd1;
   localparam logic [2:0] S_FETCH  = 3'd2;
   localparam logic [2:0] S_LATCH  = 3'd3;
   localparam logic [2:0] S_BIT_HI = 3'd4;
   localparam logic [2:0] S_BIT_LO = 3'd5;
   localparam logic [2:0] S_GAP    = 3'd6;
   localparam logic [2:0] S_TRAIL  = 3'd7;

   logic [2:0]      r_state;
   logic [c_CW-1:0] r_cnt;
   logic [7:0]      r_shift;
   logic [2:0]      r_bitcnt;
   logic [3:0]      r_pulse;
   logic [AW:0]     r_index;
   logic [AW:0]     r_len;
   logic            r_zx81;
   logic            r_is_name;
   logic            r_done;

   logic            w_stall;
   logic            w_cnt_zero;
   logic [AW:0]     w_idx_next;
   logic            w_more_bytes;
   logic [3:0]      w_pulse_next;
   logic [3:0]      w_pulse_target;

`ifdef TAPE_PLAYER_PAUSE_EN
   assign w_stall = pause & (r_state != S_IDLE);
`else
   assign w_stall = 1'b0;
`endif

   assign w_cnt_zero     = (r_cnt == '0);
   assign w_idx_next     = r_index + (AW+1)'(1);
   assign w_more_bytes   = (w_idx_next < r_len);
   assign w_pulse_next   = r_pulse + 4'd1;
   assign w_pulse_target = r_shift[7] ? 4'd9 : 4'd4;

   assign rd_addr  = r_index[AW-1:0];
   assign busy     = (r_state != S_IDLE);
   // Pause forces the line low even if it interrupts a high half-pulse.
   assign tape_out = (r_state == S_BIT_HI) && !w_stall;
   assign done     = r_done;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_pulse   <= '0;
         r_index   <= '0;
         r_len     <= '0;
         r_zx81    <= 1'b0;
         r_is_name <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            // Abort in IDLE also suppresses a simultaneous start.
            r_state <= S_IDLE;
         end else if (!w_stall) begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state   <= S_LEADIN;
                     r_len     <= length;
                     r_zx81    <= zx81;
                     r_index   <= '0;
                     r_is_name <= 1'b0;
                     r_cnt     <= c_LEADIN_LD;
                  end
               end
               S_LEADIN: begin
                  if (w_cnt_zero) begin
                     if (r_zx81) begin
                        // Blank program name: terminator bit set on an empty name.
                        r_shift   <= 8'h80;
                        r_bitcnt  <= 3'd7;
                        r_pulse   <= 4'd0;
                        r_is_name <= 1'b1;
                        r_cnt     <= c_PULSE_LD;
                        r_state   <= S_BIT_HI;
                     end else if (r_len == '0) begin
                        r_cnt   <= c_LEADIN_LD;
                        r_state <= S_TRAIL;
                     end else begin
                        r_state <= S_FETCH;
                     end
                  end else begin
                     r_cnt <= r_cnt - c_CW'(1);
                  end
               end
               S_FETCH: begin
                  r_state <= S_LATCH;
               end
               S_LATCH: begin
                  r_shift  <= rd_data;
                  r_bitcnt <= 3'd7;
                  r_pulse  <= 4'd0;
                  r_cnt    <= c_PULSE_LD;
                  r_state  <= S_BIT_HI;
               end
               S_BIT_HI: begin
                  if (w_cnt_zero) begin
                     r_cnt   <= c_PULSE_LD;
                     r_state <= S_BIT_LO;
                  end else begin
                     r_cnt <= r_cnt - c_CW'(1);
                  end
               end
               S_BIT_LO: begin
                  if (w_cnt_zero) begin
                     if (w_pulse_next < w_pulse_target) begin
                        r_pulse <= w_pulse_next;
                        r_cnt   <= c_PULSE_LD;
                        r_state <= S_BIT_HI;
                     end else begin
                        r_pulse <= 4'd0;
                        r_cnt   <= c_GAP_LD;
                        r_state <= S_GAP;
                     end
                  end else begin
                     r_cnt <= r_cnt - c_CW'(1);
                  end
               end
               S_GAP: begin
                  if (w_cnt_zero) begin
                     if (r_bitcnt != 3'd0) begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 3'd1;
                        r_cnt    <= c_PULSE_LD;
                        r_state  <= S_BIT_HI;
                     end else if (r_is_name) begin
                        // Name byte is not in the buffer, so index stays at 0.
                        r_is_name <= 1'b0;
                        if (r_len != '0) begin
                           r_state <= S_FETCH;
                        end else begin
                           r_cnt   <= c_LEADIN_LD;
                           r_state <= S_TRAIL;
                        end
                     end else if (w_more_bytes) begin
                        r_index <= w_idx_next;
                        r_state <= S_FETCH;
                     end else begin
                        r_cnt   <= c_LEADIN_LD;
                        r_state <= S_TRAIL;
                     end
                  end else begin
                     r_cnt <= r_cnt - c_CW'(1);
                  end
               end
               S_TRAIL: begin
                  if (w_cnt_zero) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt - c_CW'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_zx8x_tape_player.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_zx8x_tape_player                                          |
// | Description : Self-checking bench for zx8x_tape_player. Expected EAR       |
// |               waveform is built cycle-by-cycle from the cassette format    |
// |               rules; the observed pulse train is also decoded back to      |
// |               bytes and compared with the image.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_zx8x_tape_player;

   localparam int PULSE = 4;
   localparam int GAP   = 20;
   localparam int LEAD  = 10;
   localparam int AW    = 4;

   logic          clk_sys = 1'b0;
   logic          reset   = 1'b1;
   logic          start   = 1'b0;
   logic          abort   = 1'b0;
   logic          zx81    = 1'b0;
   logic [AW:0]   length  = '0;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          tape_out;
   logic          busy;
   logic          done;
`ifdef TAPE_PLAYER_PAUSE_EN
   logic          pause = 1'b0;
`endif

   logic [7:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model output: one entry per clock after the start edge.
   bit         q_tape[$];
   int         q_addr[$];
   logic [7:0] q_bytes[$];

   // Pulse-train decoder state.
   int pc, lowrun, bad_pulse;
   bit prev_t;
   bit dec_bits[$];

   zx8x_tape_player #(
      .PULSE_CYC (PULSE),
      .GAP_CYC   (GAP),
      .LEADIN_CYC(LEAD),
      .AW        (AW)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .zx81    (zx81),
      .length  (length),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .tape_out(tape_out),
      .busy    (busy),
      .done    (done)
`ifdef TAPE_PLAYER_PAUSE_EN
      ,
      .pause   (pause)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   // Tape buffer RAM with 1-cycle synchronous read.
   always @(posedge clk_sys) rd_data <= mem[rd_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic push_lvl(input bit lvl, input int n, input int addr);
      for (int i = 0; i < n; i++) begin
         q_tape.push_back(lvl);
         q_addr.push_back(addr);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input int addr);
      if (addr >= 0) push_lvl(1'b0, 2, addr);   // fetch latency
      for (int k = 7; k >= 0; k--) begin
         for (int p = 0; p < (b[k] ? 9 : 4); p++) begin
            push_lvl(1'b1, PULSE, -1);
            push_lvl(1'b0, PULSE, -1);
         end
         push_lvl(1'b0, GAP, -1);
      end
      q_bytes.push_back(b);
   endtask

   task automatic build_model(input bit z, input int len);
      q_tape.delete();
      q_addr.delete();
      q_bytes.delete();
      push_lvl(1'b0, LEAD, -1);
      if (z) push_byte(8'h80, -1);
      for (int i = 0; i < len; i++) push_byte(mem[i], i);
      push_lvl(1'b0, LEAD, -1);
   endtask

   task automatic decode_step(input bit t);
      if (t && !prev_t) pc++;
      if (t) lowrun = 0;
      else begin
         lowrun++;
         // A low run longer than a half-pulse ends the current bit.
         if (lowrun == 10 && pc > 0) begin
            dec_bits.push_back(pc == 9);
            if (pc != 4 && pc != 9) bad_pulse++;
            pc = 0;
         end
      end
      prev_t = t;
   endtask

   task automatic run_play(input bit z, input int len, input bit poke_start, output int busy_cnt);
      int L;
      logic [7:0] db;
      build_model(z, len);
      pc = 0; lowrun = 0; bad_pulse = 0; prev_t = 1'b0; dec_bits.delete();
      busy_cnt = 0;
      @(negedge clk_sys);
      zx81 = z; length = (AW+1)'(len); start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      L = q_tape.size();
      for (int j = 0; j < L; j++) begin
         check_eq("tape_out", tape_out, q_tape[j]);
         check_eq("busy", busy, 1);
         check_eq("done_early", done, 0);
         if (q_addr[j] >= 0) check_eq("rd_addr", rd_addr, q_addr[j]);
         if (busy) busy_cnt++;
         decode_step(tape_out);
         if (j == L/3) begin
            length = (AW+1)'($urandom_range(0, 1<<AW));
            zx81   = 1'($urandom_range(0, 1));
         end
         start = poke_start && (j == L/2);
         @(negedge clk_sys);
      end
      start = 1'b0;
      check_eq("done_pulse", done, 1);
      check_eq("busy_end", busy, 0);
      check_eq("tape_end", tape_out, 0);
      check_eq("bad_pulse_cnt", bad_pulse, 0);
      check_eq("decoded_bits", dec_bits.size(), 8*q_bytes.size());
      for (int i = 0; i < q_bytes.size(); i++) begin
         if (dec_bits.size() >= 8*(i+1)) begin
            for (int k = 0; k < 8; k++) db[7-k] = dec_bits[8*i+k];
            check_eq("decoded_byte", db, q_bytes[i]);
         end
      end
      @(negedge clk_sys);
      check_eq("done_once", done, 0);
   endtask

   initial begin
      int bc;
      int rises;
      int dcnt;
      bit found;

      // Reset values
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      check_eq("rst_tape", tape_out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_addr", rd_addr, 0);
      reset = 1'b0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);

      // start and abort together in IDLE: nothing happens
      @(negedge clk_sys);
      start = 1'b1; abort = 1'b1;
      @(negedge clk_sys);
      start = 1'b0; abort = 1'b0;
      check_eq("start_abort_idle", busy, 0);
      @(negedge clk_sys);
      check_eq("start_abort_idle2", busy, 0);

      // ZX80, one byte 0x80
      mem[0] = 8'h80;
      run_play(1'b0, 1, 1'b0, bc);
      // ZX81 name byte then 0x00
      mem[0] = 8'h00;
      run_play(1'b1, 1, 1'b0, bc);
      // Empty ZX80 image: start cycle + lead-in + trailer
      run_play(1'b0, 0, 1'b0, bc);
      check_eq("busy_span", bc + 1, 1 + LEAD + LEAD);
      // Three bytes, with start re-asserted mid-playback
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
      run_play(1'b0, 3, 1'b1, bc);

      // Abort during the third pulse of byte 0
      mem[0] = 8'($urandom);
      @(negedge clk_sys);
      zx81 = 1'b0; length = 1; start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      rises = 0; found = 1'b0; prev_t = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         if (tape_out && !prev_t) rises++;
         prev_t = tape_out;
         if (rises == 3) found = 1'b1;
         else @(negedge clk_sys);
      end
      check_eq("abort_wait", found, 1);
      abort = 1'b1;
      @(negedge clk_sys);
      abort = 1'b0;
      check_eq("abort_tape", tape_out, 0);
      check_eq("abort_busy", busy, 0);
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) dcnt++;
         @(negedge clk_sys);
      end
      check_eq("abort_no_done", dcnt, 0);
      run_play(1'b0, 1, 1'b0, bc);

      // Reset during BIT_HI of byte 1
      @(negedge clk_sys);
      zx81 = 1'b0; length = 3; start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         if (rd_addr == 1 && tape_out) found = 1'b1;
         else @(negedge clk_sys);
      end
      check_eq("reset_wait", found, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      check_eq("midrst_tape", tape_out, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_addr", rd_addr, 0);
      check_eq("midrst_done", done, 0);
      reset = 1'b0;

      // Randomized images
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
         run_play(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)), bc);
      end
      // Whole buffer (length = 2^AW)
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
      run_play(1'b1, 1<<AW, 1'b0, bc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
